gpr_wb_arbiter: RTL

Write-back arbiter driving the single write port (A3/WD/RegWr) of the MIPS general-purpose register file. It merges single-cycle pipeline results (ALU/load) with results from the long-latency multiply/divide unit, which are buffered in a small FIFO. A starvation guard briefly stalls the pipeline so queued results always retire. A scoreboard reports which registers still have queued writes, so the hazard unit can interlock.

---
 rtl/gpr_wb_arbiter.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/gpr_wb_arbiter.sv
// Write-back arbiter for the GPR write port: pipeline results win, mult/div results queue in a FIFO.
// Define GPR_WB_SCOREBOARD_EN to build the pending-register bitmap; otherwise pending is 0.
module gpr_wb_arbiter #(
  parameter int FIFO_DEPTH   = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        pipe_we,
  input  logic [4:0]                  pipe_addr,
  input  logic [31:0]                 pipe_data,
  input  logic                        md_valid,
  output logic                        md_ready,
  input  logic [4:0]                  md_addr,
  input  logic [31:0]                 md_data,
  output logic [4:0]                  rf_a3,
  output logic [31:0]                 rf_wd,
  output logic                        rf_regwr,
  output logic                        stall_req,
  output logic [31:0]                 pending,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int WW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic {
    NORMAL,
    STEAL
  } state_e;

  state_e          state_q, state_d;
  logic [WW-1:0]   wait_q, wait_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [LW-1:0]   level_q, level_d;
  logic [4:0]      rf_a3_q, rf_a3_d;
  logic [31:0]     rf_wd_q, rf_wd_d;
  logic            rf_regwr_q, rf_regwr_d;
  logic            stall_q, stall_d;

  logic [4:0]      mem_addr_q [FIFO_DEPTH];
  logic [31:0]     mem_data_q [FIFO_DEPTH];

  logic full, empty, push, pipe_wr, pop;

  always_comb begin
    full     = (level_q == LW'(FIFO_DEPTH));
    empty    = (level_q == '0);
    md_ready = !full && !reset;
    // address-0 results are acknowledged but never stored
    push     = md_valid && md_ready && (md_addr != 5'd0);
    pipe_wr  = pipe_we && (pipe_addr != 5'd0);
    pop      = !pipe_wr && !empty;

    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    level_d  = level_q + LW'(push) - LW'(pop);

    rf_regwr_d = pipe_wr || pop;
    rf_a3_d    = rf_a3_q;
    rf_wd_d    = rf_wd_q;
    if (pipe_wr) begin
      rf_a3_d = pipe_addr;
      rf_wd_d = pipe_data;
    end else if (pop) begin
      rf_a3_d = mem_addr_q[rd_ptr_q];
      rf_wd_d = mem_data_q[rd_ptr_q];
    end

    state_d = state_q;
    wait_d  = wait_q;
    stall_d = stall_q;
    unique case (state_q)
      NORMAL: begin
        if (empty || pop) begin
          wait_d = '0;
        end else begin
          wait_d = wait_q + WW'(1);
          if (wait_d == WW'(STARVE_LIMIT)) begin
            state_d = STEAL;
            stall_d = 1'b1;
          end
        end
      end
      STEAL: begin
        if (pop) begin
          state_d = NORMAL;
          stall_d = 1'b0;
          wait_d  = '0;
        end
      end
      default: state_d = NORMAL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= NORMAL;
      wait_q     <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      level_q    <= '0;
      rf_a3_q    <= '0;
      rf_wd_q    <= '0;
      rf_regwr_q <= 1'b0;
      stall_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_q     <= wait_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      level_q    <= level_d;
      rf_a3_q    <= rf_a3_d;
      rf_wd_q    <= rf_wd_d;
      rf_regwr_q <= rf_regwr_d;
      stall_q    <= stall_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_addr_q[wr_ptr_q] <= md_addr;
      mem_data_q[wr_ptr_q] <= md_data;
    end
  end

  assign rf_a3      = rf_a3_q;
  assign rf_wd      = rf_wd_q;
  assign rf_regwr   = rf_regwr_q;
  assign stall_req  = stall_q;
  assign fifo_level = level_q;

`ifdef GPR_WB_SCOREBOARD_EN
  // a bit stays set while any live entry still targets that register
  logic [31:0]   pend_vec;
  logic [AW-1:0] idx;
  always_comb begin
    pend_vec = '0;
    idx      = '0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      idx = rd_ptr_q + AW'(i);
      if (LW'(i) < level_q) begin
        pend_vec[mem_addr_q[idx]] = 1'b1;
      end
    end
  end
  assign pending = pend_vec;
`else
  assign pending = 32'h0;
`endif

endmodule
